// File: rtl/reg_file_cc_pkg.sv
// ============================================================================
//  Module   : lc3_pkg
//  Purpose  : Shared LC-3 datapath types, NZP encodings and branch helper.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package lc3_pkg;

  typedef logic [2:0]  reg_idx_t;
  typedef logic [15:0] word_t;
  typedef logic [2:0]  nzp_t;

  localparam nzp_t NZP_N = 3'b100;
  localparam nzp_t NZP_Z = 3'b010;
  localparam nzp_t NZP_P = 3'b001;

  // Branch is taken when any requested condition matches the current code.
  function automatic logic br_eval(input nzp_t mask, input nzp_t cc);
    return |(mask & cc);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_cc_if.sv
// ============================================================================
//  Module   : reg_file_cc_if
//  Purpose  : Operand/write-back/condition-code bundle between control,
//             datapath bus and the register file.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface reg_file_cc_if;
  import lc3_pkg::*;

  reg_idx_t sr1;
  reg_idx_t sr2;
  reg_idx_t dr;
  logic     ld_reg;
  logic     ld_cc;
  word_t    bus_in;
  nzp_t     br_nzp;
  word_t    ra;
  word_t    rb;
  nzp_t     nzp;
  logic     br_taken;

  modport master (
    output sr1, sr2, dr, ld_reg, ld_cc, bus_in, br_nzp,
    input  ra, rb, nzp, br_taken
  );

  modport slave (
    input  sr1, sr2, dr, ld_reg, ld_cc, bus_in, br_nzp,
    output ra, rb, nzp, br_taken
  );

endinterface

`default_nettype wire

// File: rtl/reg_file_cc_nzp_gen.sv
// ============================================================================
//  Module   : nzp_gen
//  Purpose  : Classifies a datapath word into a one-hot {N,Z,P} code.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nzp_gen
  import lc3_pkg::*;
(
  input  word_t data,
  output nzp_t  nzp
);

  always_comb begin
    nzp = NZP_P;
    if (data[15]) begin
      nzp = NZP_N;
    end else if (data == '0) begin
      nzp = NZP_Z;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_cc.sv
// ============================================================================
//  Module   : reg_file_cc
//  Purpose  : LC-3 eight-entry register file with NZP condition codes and
//             branch evaluation. Define RF_BYPASS_EN for write-through reads.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_cc
  import lc3_pkg::*;
#(
  parameter int         DATA_W   = 16,
  parameter int         NUM_REGS = 8,
  parameter logic [2:0] CC_RST   = 3'b010
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  reg_file_cc_if.slave rf
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  nzp_t              r_nzp;

  logic [IDX_W-1:0]  w_sr1_idx;
  logic [IDX_W-1:0]  w_sr2_idx;
  logic [IDX_W-1:0]  w_dr_idx;
  logic [DATA_W-1:0] w_ra_arr;
  logic [DATA_W-1:0] w_rb_arr;
  nzp_t              w_bus_nzp;

  assign w_sr1_idx = rf.sr1;
  assign w_sr2_idx = rf.sr2;
  assign w_dr_idx  = rf.dr;

  nzp_gen u_nzp_gen (
    .data (rf.bus_in),
    .nzp  (w_bus_nzp)
  );

  // Reset wins over any load request in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (rf.ld_reg) begin
      r_regs[w_dr_idx] <= rf.bus_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_nzp <= CC_RST;
    end else if (rf.ld_cc) begin
      r_nzp <= w_bus_nzp;
    end
  end

  assign w_ra_arr = r_regs[w_sr1_idx];
  assign w_rb_arr = r_regs[w_sr2_idx];

`ifdef RF_BYPASS_EN
  logic w_fwd_a;
  logic w_fwd_b;

  // Forward only writes that will actually land this edge.
  assign w_fwd_a = rst_n & rf.ld_reg & (w_sr1_idx == w_dr_idx);
  assign w_fwd_b = rst_n & rf.ld_reg & (w_sr2_idx == w_dr_idx);

  assign rf.ra = w_fwd_a ? rf.bus_in : w_ra_arr;
  assign rf.rb = w_fwd_b ? rf.bus_in : w_rb_arr;
`else
  assign rf.ra = w_ra_arr;
  assign rf.rb = w_rb_arr;
`endif

  assign rf.nzp      = r_nzp;
  assign rf.br_taken = br_eval(rf.br_nzp, r_nzp);

endmodule

`default_nettype wire

// File: tb/tb_reg_file_cc.sv
// ============================================================================
//  Module   : tb_reg_file_cc
//  Purpose  : Self-checking bench for reg_file_cc (directed table, corner
//             sequences and randomized traffic against a reference model).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_cc;

  logic clk;
  logic rst_n;

  reg_file_cc_if rif ();

  reg_file_cc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rn;
    logic        ldr;
    logic        ldc;
    logic [2:0]  dr;
    logic [15:0] bus;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [2:0]  bn;
    logic [15:0] era;
    logic [15:0] erb;
    logic [2:0]  enzp;
    logic        ebr;
  } vec_t;

  vec_t vecs [11];

  logic [15:0] m_regs [8];
  logic [2:0]  m_nzp;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic ldr, input logic ldc,
                       input logic [2:0] d, input logic [15:0] b,
                       input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] bn);
    rst_n      = rn;
    rif.ld_reg = ldr;
    rif.ld_cc  = ldc;
    rif.dr     = d;
    rif.bus_in = b;
    rif.sr1    = s1;
    rif.sr2    = s2;
    rif.br_nzp = bn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] cc_of(input logic [15:0] w);
    if ($signed(w) < 0) return 3'b100;
    if (w == 16'h0000)  return 3'b010;
    return 3'b001;
  endfunction

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i), 3'b010);
      #1;
      check({tag, "_ra"}, rif.ra, 16'h0000);
      check({tag, "_rb"}, rif.rb, 16'h0000);
    end
    check({tag, "_nzp"}, 16'(rif.nzp), 16'h0002);
    check({tag, "_br"}, 16'(rif.br_taken), 16'h0001);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_ra;
    logic [15:0] exp_rb;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'd3, 16'h1234, 3'd3, 3'd0, 3'b000, 16'h1234, 16'h0000, 3'b010, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 3'd0, 16'h8000, 3'd3, 3'd3, 3'b100, 16'h1234, 16'h1234, 3'b100, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 3'd0, 16'h0000, 3'd0, 3'd3, 3'b001, 16'h0000, 16'h1234, 3'b010, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 3'd0, 16'h7FFF, 3'd3, 3'd0, 3'b001, 16'h1234, 16'h0000, 3'b001, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 3'd7, 16'hFFFE, 3'd7, 3'd3, 3'b011, 16'hFFFE, 16'h1234, 3'b100, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 3'd0, 16'h0000, 3'd7, 3'd7, 3'b101, 16'hFFFE, 16'hFFFE, 3'b010, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'd2, 16'h5555, 3'd7, 3'd0, 3'b011, 16'hFFFE, 16'h0000, 3'b010, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd2, 3'b000, 16'h0000, 16'h0000, 3'b010, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 3'd0, 16'h0001, 3'd0, 3'd7, 3'b111, 16'h0001, 16'hFFFE, 3'b001, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'd3, 16'h8000, 3'd3, 3'd0, 3'b001, 16'h8000, 16'h0001, 3'b001, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 3'd5, 16'hABCD, 3'd3, 3'd5, 3'b010, 16'h0000, 16'h0000, 3'b010, 1'b1};

    // Reset with a pending write of all-ones: reset must win.
    drive(1'b0, 1'b1, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 3'b000);
    tick();
    check_all_zero("reset");

    // Same-cycle visibility of a write, then one-cycle-later visibility.
    drive(1'b1, 1'b1, 1'b0, 3'd3, 16'h1234, 3'd3, 3'd0, 3'b000);
    #1;
`ifdef RF_BYPASS_EN
    check("samecyc_ra", rif.ra, 16'h1234);
`else
    check("samecyc_ra", rif.ra, 16'h0000);
`endif
    check("samecyc_rb", rif.rb, 16'h0000);
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, 3'b000);
    #1;
    check("nextcyc_ra", rif.ra, 16'h1234);
    check("nextcyc_rb", rif.rb, 16'h0000);

    // Directed table: load phase, one edge, then read phase.
    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].rn, vecs[v].ldr, vecs[v].ldc, vecs[v].dr, vecs[v].bus,
            3'd0, 3'd0, 3'b000);
      tick();
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, vecs[v].s1, vecs[v].s2, vecs[v].bn);
      #1;
      check($sformatf("vec%0d_ra", v), rif.ra, vecs[v].era);
      check($sformatf("vec%0d_rb", v), rif.rb, vecs[v].erb);
      check($sformatf("vec%0d_nzp", v), 16'(rif.nzp), 16'(vecs[v].enzp));
      check($sformatf("vec%0d_br", v), 16'(rif.br_taken), 16'(vecs[v].ebr));
    end

    // Sweep: fill all registers, read every (sr1, sr2) pair.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'(i), 16'(16'h1111 * (i + 1)), 3'd0, 3'd0, 3'b000);
      tick();
    end
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'(a), 3'(b), 3'b000);
        #1;
        check($sformatf("sweep_ra_%0d_%0d", a, b), rif.ra, 16'(16'h1111 * (a + 1)));
        check($sformatf("sweep_rb_%0d_%0d", a, b), rif.rb, 16'(16'h1111 * (b + 1)));
      end
    end

    // Reset arriving partway through a second sweep.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 3'(i), 16'(16'h2222 * (i + 1)), 3'd0, 3'd0, 3'b000);
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 3'd4, 16'hAAAA, 3'd4, 3'd4, 3'b000);
    tick();
    check_all_zero("midsweep_reset");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_nzp = 3'b010;
    for (int c = 0; c < 400; c++) begin
      logic        rn;
      logic        ldr;
      logic        ldc;
      logic [2:0]  d;
      logic [2:0]  s1;
      logic [2:0]  s2;
      logic [2:0]  bn;
      logic [15:0] bus;
      rn  = ($urandom_range(0, 31) != 0);
      ldr = 1'($urandom_range(0, 1));
      ldc = 1'($urandom_range(0, 1));
      d   = 3'($urandom_range(0, 7));
      s1  = ($urandom_range(0, 3) == 0) ? d : 3'($urandom_range(0, 7));
      s2  = ($urandom_range(0, 3) == 0) ? d : 3'($urandom_range(0, 7));
      bn  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       bus = 16'h0000;
        1:       bus = 16'h8000;
        2:       bus = 16'h7FFF;
        default: bus = 16'($urandom);
      endcase
      drive(rn, ldr, ldc, d, bus, s1, s2, bn);
      #1;
      exp_ra = m_regs[s1];
      exp_rb = m_regs[s2];
`ifdef RF_BYPASS_EN
      if (rn && ldr && s1 == d) exp_ra = bus;
      if (rn && ldr && s2 == d) exp_rb = bus;
`endif
      check($sformatf("rand%0d_ra", c), rif.ra, exp_ra);
      check($sformatf("rand%0d_rb", c), rif.rb, exp_rb);
      check($sformatf("rand%0d_nzp", c), 16'(rif.nzp), 16'(m_nzp));
      check($sformatf("rand%0d_br", c), 16'(rif.br_taken), 16'((bn & m_nzp) != 3'b000));
      tick();
      if (!rn) begin
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_nzp = 3'b010;
      end else begin
        if (ldr) m_regs[d] = bus;
        if (ldc) m_nzp = cc_of(bus);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
